// File: rtl/matmul_pkg.sv
// Shared helpers for the NxN sequential matrix multiplier: width derivation,
// FSM state encoding and flat-vector element indexing.
package matmul_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StCompute
  } state_e;

  // Ceiling log2; returns 0 for v <= 1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // Result element width: full product plus growth for an N-term reduction.
  function automatic int unsigned calc_aw(input int unsigned dw, input int unsigned n);
    return 2 * dw + clog2(n);
  endfunction

  // Row-major element position of (i,j) inside a flat NxN vector.
  function automatic int unsigned elem_idx(input int unsigned i, input int unsigned j,
                                           input int unsigned n);
    return i * n + j;
  endfunction

endpackage

// File: rtl/mac_cell.sv
// Single multiply-accumulate cell: acc <= (clr ? 0 : acc) + ext(a*b) when enabled.
module mac_cell #(
  parameter int unsigned DW     = 8,
  parameter int unsigned AW     = 18,
  parameter bit          SIGNED = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en_i,
  input  logic          clr_i,
  input  logic [DW-1:0] a_i,
  input  logic [DW-1:0] b_i,
  output logic [AW-1:0] acc_o
);

  logic [AW-1:0] prod_ext;
  logic [AW-1:0] acc_q, acc_d;

  if (SIGNED) begin : g_signed
    logic signed [2*DW-1:0] a_ext, b_ext, prod;
    assign a_ext    = {{DW{a_i[DW-1]}}, a_i};
    assign b_ext    = {{DW{b_i[DW-1]}}, b_i};
    assign prod     = a_ext * b_ext;
    assign prod_ext = {{(AW-2*DW){prod[2*DW-1]}}, prod};
  end else begin : g_unsigned
    logic [2*DW-1:0] prod;
    assign prod     = {{DW{1'b0}}, a_i} * {{DW{1'b0}}, b_i};
    assign prod_ext = {{(AW-2*DW){1'b0}}, prod};
  end

  // Next accumulator value; clr restarts the reduction from zero.
  always_comb begin
    acc_d = (clr_i ? '0 : acc_q) + prod_ext;
  end

  // Accumulator register, advanced only on compute cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else if (en_i) begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/matmul_nxn_seq.sv
// NxN integer matrix multiplier, one k-step per cycle over N*N MAC cells.
// Computes C = A*B, or C = C + A*B when acc_en is sampled high with start.
module matmul_nxn_seq
  import matmul_pkg::*;
#(
  parameter int unsigned N      = 4,
  parameter int unsigned DW     = 8,
  parameter bit          SIGNED = 1'b0
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start_i,
  input  logic                            acc_en_i,
  input  logic [N*N*DW-1:0]               a_flat_i,
  input  logic [N*N*DW-1:0]               b_flat_i,
  output logic                            busy_o,
  output logic                            done_o,
  output logic [N*N*calc_aw(DW, N)-1:0]   c_flat_o
);

  localparam int unsigned AW = calc_aw(DW, N);
  localparam int unsigned KW = clog2(N);

  state_e             state_q, state_d;
  logic [KW-1:0]      k_q, k_d;
  logic               done_q, done_d;
  logic [N*N*DW-1:0]  a_q, b_q;
  logic               acc_en_q;
  logic [N*N*AW-1:0]  hold_q;
  logic [N*N*AW-1:0]  acc_flat;
  logic               load;
  logic               mac_en;
  logic               mac_clr;
  logic [DW-1:0]      a_sel [N];
  logic [DW-1:0]      b_sel [N];

  // FSM next-state: accept start in idle, step k each compute cycle, finish at k==N-1.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    done_d  = 1'b0;
    load    = 1'b0;
    mac_en  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d = StCompute;
          k_d     = '0;
          load    = 1'b1;
        end
      end
      StCompute: begin
        mac_en = 1'b1;
        k_d    = k_q + KW'(1);
        if (k_q == KW'(N - 1)) begin
          state_d = StIdle;
          k_d     = '0;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // First k-step of a non-accumulating operation discards the old result.
  assign mac_clr = (k_q == '0) && !acc_en_q;

  // Operand muxes: column k of A feeds every row, row k of B feeds every column.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      a_sel[i] = a_q[elem_idx(i, int'(k_q), N)*DW +: DW];
      b_sel[i] = b_q[elem_idx(int'(k_q), i, N)*DW +: DW];
    end
  end

  // Control state and operand latches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      k_q      <= '0;
      done_q   <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      acc_en_q <= 1'b0;
      hold_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      done_q  <= done_d;
      if (load) begin
        a_q      <= a_flat_i;
        b_q      <= b_flat_i;
        acc_en_q <= acc_en_i;
        // Snapshot of the visible result so partial sums stay hidden while busy.
        hold_q   <= acc_flat;
      end
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_row
    for (genvar gj = 0; gj < N; gj++) begin : g_col
      mac_cell #(
        .DW     (DW),
        .AW     (AW),
        .SIGNED (SIGNED)
      ) u_mac (
        .clk   (clk),
        .rst   (rst),
        .en_i  (mac_en),
        .clr_i (mac_clr),
        .a_i   (a_sel[gi]),
        .b_i   (b_sel[gj]),
        .acc_o (acc_flat[elem_idx(gi, gj, N)*AW +: AW])
      );
    end
  end

  assign busy_o = (state_q == StCompute);
  assign done_o = done_q;
  // Idle accumulators hold the last completed result; while busy show the snapshot.
  assign c_flat_o = busy_o ? hold_q : acc_flat;

endmodule
